// File: rtl/fetch_pc_pkg.sv
// Shared CPU definitions used by the fetch stage: fetch state encoding,
// instruction width and sequential PC increment.
package fetch_pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam int          INST_WIDTH = 32;
  localparam logic [31:0] PC_INC     = 32'd4;

endpackage

// File: rtl/fetch_pc.sv
// Program counter for the fetch stage: boot, sequential fetch, stall, redirect,
// and a sticky fault on misaligned or out-of-range fetch addresses.
//
// state | meaning
// BOOT  | first cycle after reset, pc = RESET_VECTOR, nothing valid yet
// RUN   | fetching; pc advances by 4 unless stalled, redirects on is_jump
// FAULT | halted on bad address; only a jump to a legal target resumes
module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
  parameter int          IMEM_ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  is_jump,
  input  logic                  is_stall,
  input  logic [INST_WIDTH-1:0] jump_addr,
  output logic [INST_WIDTH-1:0] pc,
  output logic [INST_WIDTH-1:0] pc_d,
  output logic                  inst_valid,
  output logic                  fetch_fault
);

  fetch_state_e          state_q, state_nxt;
  logic [INST_WIDTH-1:0] pc_nxt, pc_d_nxt, pc_inc;
  logic                  valid_nxt, fault_nxt;

  // Word-aligned and inside the instruction memory word range.
  function automatic logic addr_legal(input logic [INST_WIDTH-1:0] a);
    return (a[1:0] == 2'b00) &&
           (64'(a[INST_WIDTH-1:2]) < (64'd1 << IMEM_ADDR_WIDTH));
  endfunction

  assign pc_inc = pc + PC_INC;

  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc;
    pc_d_nxt  = pc_d;
    valid_nxt = inst_valid;
    fault_nxt = fetch_fault;
    if (is_jump) begin
      pc_nxt    = jump_addr;
      pc_d_nxt  = '0;
      valid_nxt = 1'b0;
      if (addr_legal(jump_addr)) begin
        state_nxt = RUN;
        fault_nxt = 1'b0;
      end else begin
        state_nxt = FAULT;
        fault_nxt = 1'b1;
      end
    end else begin
      case (state_q)
        BOOT: begin
          state_nxt = RUN;
          pc_nxt    = RESET_VECTOR;
          pc_d_nxt  = '0;
          valid_nxt = 1'b0;
        end
        RUN: begin
          // A pc that walked off the end of memory (or a bad reset vector)
          // faults instead of wrapping.
          if (!addr_legal(pc)) begin
            state_nxt = FAULT;
            fault_nxt = 1'b1;
            valid_nxt = 1'b0;
            pc_d_nxt  = '0;
          end else if (!is_stall) begin
            pc_nxt    = pc_inc;
            pc_d_nxt  = pc;
            valid_nxt = 1'b1;
          end
        end
        FAULT: begin
          valid_nxt = 1'b0;
          fault_nxt = 1'b1;
        end
        default: begin
          state_nxt = BOOT;
          pc_nxt    = RESET_VECTOR;
          pc_d_nxt  = '0;
          valid_nxt = 1'b0;
          fault_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pc          <= RESET_VECTOR;
      pc_d        <= '0;
      inst_valid  <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      pc          <= pc_nxt;
      pc_d        <= pc_d_nxt;
      inst_valid  <= valid_nxt;
      fetch_fault <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc: expected outputs are queued as each step is
// driven and checked after the clock edge (or immediately for async reset).
module tb_fetch_pc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        is_jump;
  logic        is_stall;
  logic [31:0] jump_addr;
  logic [31:0] pc;
  logic [31:0] pc_d;
  logic        inst_valid;
  logic        fetch_fault;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_d;
    logic        valid;
    logic        fault;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  fetch_pc #(
    .RESET_VECTOR   (32'h0000_0000),
    .IMEM_ADDR_WIDTH(12)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .is_jump    (is_jump),
    .is_stall   (is_stall),
    .jump_addr  (jump_addr),
    .pc         (pc),
    .pc_d       (pc_d),
    .inst_valid (inst_valid),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic [31:0] e_pc, input logic [31:0] e_pc_d,
                      input logic e_v, input logic e_f, input string tag);
    exp_t e;
    e.pc = e_pc; e.pc_d = e_pc_d; e.valid = e_v; e.fault = e_f; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: observed=0 entries required=1");
      return;
    end
    e = exp_q.pop_front();
    vectors++;
    assert ({pc, pc_d, inst_valid, fetch_fault} === {e.pc, e.pc_d, e.valid, e.fault})
    else begin
      miscompares++;
      $error("FAIL %s: observed pc=%h pc_d=%h valid=%b fault=%b required pc=%h pc_d=%h valid=%b fault=%b",
             e.tag, pc, pc_d, inst_valid, fetch_fault, e.pc, e.pc_d, e.valid, e.fault);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, clock, compare.
  task automatic step(input logic j, input logic s, input logic [31:0] a,
                      input logic [31:0] e_pc, input logic [31:0] e_pc_d,
                      input logic e_v, input logic e_f, input string tag);
    is_jump = j; is_stall = s; jump_addr = a;
    push(e_pc, e_pc_d, e_v, e_f, tag);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    rst_n = 1'b0; is_jump = 1'b0; is_stall = 1'b0; jump_addr = '0;
    #2;
    push(32'h0, 32'h0, 1'b0, 1'b0, "reset_values");
    check_pop();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // boot and sequential fetch
    step(0, 0, 0, 32'h00, 32'h00, 0, 0, "boot_cycle1");
    step(0, 0, 0, 32'h04, 32'h00, 1, 0, "seq_cycle2");
    step(0, 0, 0, 32'h08, 32'h04, 1, 0, "seq_cycle3");
    step(0, 0, 0, 32'h0C, 32'h08, 1, 0, "seq_0c");
    step(0, 0, 0, 32'h10, 32'h0C, 1, 0, "seq_10");

    // stall hold
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 32'h10, 32'h0C, 1, 0, "stall_hold");
    step(0, 0, 0, 32'h14, 32'h10, 1, 0, "stall_release");

    // jump overrides stall, one bubble
    step(1, 1, 32'h100, 32'h100, 32'h0, 0, 0, "jump_with_stall");
    step(0, 0, 0, 32'h104, 32'h100, 1, 0, "after_jump");

    // misaligned target faults and holds
    step(1, 0, 32'h102, 32'h102, 32'h0, 0, 1, "misaligned_jump");
    for (int i = 0; i < 5; i++)
      step(0, i[0], 0, 32'h102, 32'h0, 0, 1, "fault_hold");
    step(1, 0, 32'h4000, 32'h4000, 32'h0, 0, 1, "out_of_range_jump");
    step(1, 1, 32'h200, 32'h200, 32'h0, 0, 0, "fault_recover");
    step(0, 0, 0, 32'h204, 32'h200, 1, 0, "recover_seq");

    // end of instruction memory: last word delivered, then fault, no wrap
    step(1, 0, 32'h3FFC, 32'h3FFC, 32'h0, 0, 0, "jump_last_word");
    step(0, 0, 0, 32'h4000, 32'h3FFC, 1, 0, "last_word_valid");
    step(0, 0, 0, 32'h4000, 32'h0, 0, 1, "end_of_mem_fault");
    step(0, 0, 0, 32'h4000, 32'h0, 0, 1, "end_of_mem_hold");

    // asynchronous reset while in FAULT, with a jump pending
    #3;
    is_jump = 1'b1; jump_addr = 32'h80;
    rst_n = 1'b0;
    #1;
    push(32'h0, 32'h0, 0, 0, "async_reset_fault");
    check_pop();
    @(posedge clk); #1;
    push(32'h0, 32'h0, 0, 0, "reset_ignores_jump");
    check_pop();
    is_jump = 1'b0;
    rst_n = 1'b1;
    step(0, 0, 0, 32'h00, 32'h00, 0, 0, "reboot_cycle1");
    step(0, 0, 0, 32'h04, 32'h00, 1, 0, "reboot_cycle2");
    step(0, 0, 0, 32'h08, 32'h04, 1, 0, "reboot_cycle3");

    // asynchronous reset during a stall
    step(0, 1, 0, 32'h08, 32'h04, 1, 0, "pre_reset_stall");
    #3;
    rst_n = 1'b0;
    #1;
    push(32'h0, 32'h0, 0, 0, "async_reset_stall");
    check_pop();
    @(posedge clk); #1;
    is_stall = 1'b0;
    rst_n = 1'b1;
    step(0, 0, 0, 32'h00, 32'h00, 0, 0, "reboot2_cycle1");
    step(0, 0, 0, 32'h04, 32'h00, 1, 0, "reboot2_cycle2");

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: observed=%0d entries required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter IMEM_ADDR_WIDTH, default 12, is the instruction-memory word-address width (legal fetch range is 0 .. 4*2**IMEM_ADDR_WIDTH-1).
REQ-003 The clock port SHALL be `clk  input  1`, the single clock; all state updates on its rising edge.
REQ-004 The reset port SHALL be `rst_n  input  1`, asynchronous and active-low.
REQ-005 `is_jump  input  1` SHALL mean redirect request from execute; same signal drives the instruction-memory flush.
REQ-006 `is_stall  input  1` SHALL mean hazard-unit hold; same signal drives the instruction-memory hold.
REQ-007 `jump_addr  input  32` SHALL be the redirect target, sampled only when is_jump=1.
REQ-008 `pc  output  32` SHALL be the fetch address presented to instruction memory in the current cycle.
REQ-009 `pc_d  output  32` SHALL be the address of the instruction the memory currently outputs (aligned with its inst output).
REQ-010 `inst_valid  output  1` SHALL mean inst/pc_d hold a real instruction for decode.
REQ-011 `fetch_fault  output  1` SHALL mean the fetch unit is halted on a misaligned or out-of-range target.

Function
REQ-012 The block SHALL implement states BOOT, RUN, FAULT in a registered state register.
REQ-013 BOOT SHALL last exactly one cycle after reset release: pc=RESET_VECTOR, inst_valid=0, next state RUN.
REQ-014 In RUN with is_jump=0 and is_stall=0, the block SHALL set pc<=pc+4, pc_d<=pc and inst_valid<=1 on each edge.
REQ-015 In RUN with is_stall=1 and is_jump=0, the block SHALL hold pc, pc_d and inst_valid unchanged.
REQ-016 When is_jump=1, the block SHALL set pc<=jump_addr, pc_d<=0 and inst_valid<=0, matching the memory flush (one bubble); is_jump overrides is_stall in every state.
REQ-017 A jump target is illegal when jump_addr[1:0]!=0 or jump_addr[31:2]>=2**IMEM_ADDR_WIDTH; an illegal target SHALL set state<=FAULT, pc<=jump_addr, inst_valid<=0 and fetch_fault<=1.
REQ-018 A sequential pc+4 that reaches 4*2**IMEM_ADDR_WIDTH SHALL set state<=FAULT, fetch_fault<=1 and inst_valid<=0 on that edge, with no wrap to 0.
REQ-019 In FAULT, the block SHALL hold pc, keep inst_valid=0 and fetch_fault=1; only is_jump with a legal target returns it to RUN (fetch_fault<=0, normal redirect per REQ-016).
REQ-020 pc+4 SHALL be 32-bit modular arithmetic; overflow is covered by REQ-018.
REQ-021 Fetch-to-decode latency SHALL be one cycle: pc_d/inst_valid in cycle n+1 describe pc of cycle n.
REQ-022 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-023 On rst_n=0, regardless of state or in-flight jump/stall, the block SHALL immediately set state=BOOT, pc=RESET_VECTOR, pc_d=0, inst_valid=0 and fetch_fault=0.
REQ-024 Inputs SHALL be ignored while rst_n=0; the first update SHALL occur on the first rising edge with rst_n=1.

Structure
REQ-025 The state enumeration (BOOT, RUN, FAULT), the instruction width constant 32 and the PC increment constant 4 SHALL reside in the shared CPU package.
REQ-026 The block SHALL be a single flat module; legality check is an internal function, no sub-module.

Verification
REQ-027 The bench SHALL cover reset and sequence: RESET_VECTOR=0, release rst_n -> cycle 1 pc=0/valid=0; cycle 2 pc=4, pc_d=0, valid=1; cycle 3 pc=8, pc_d=4.
REQ-028 The bench SHALL cover stall: with pc=0x10, is_stall=1 for 3 cycles -> pc=0x10, pc_d=0x0C, valid=1 held; release -> pc=0x14, pc_d=0x10.
REQ-029 The bench SHALL cover jump plus stall: is_jump=1, is_stall=1, jump_addr=0x100 -> next pc=0x100, pc_d=0, valid=0; following cycle pc=0x104, pc_d=0x100, valid=1.
REQ-030 The bench SHALL cover faults: jump_addr=0x102 -> fetch_fault=1, valid=0, pc held at 0x102 for 5 cycles; then jump_addr=0x200 -> fetch_fault=0, pc=0x200.
REQ-031 The bench SHALL cover end of memory: IMEM_ADDR_WIDTH=12, pc=0x3FFC unstalled -> pc_d=0x3FFC valid for one cycle, then fetch_fault=1, valid=0, no wrap to 0.
REQ-032 The bench SHALL cover reset mid-operation: assert rst_n=0 asynchronously in FAULT or mid-stall -> outputs reach reset values before the next clock edge; release -> BOOT then RUN from RESET_VECTOR.
